div_sqrt_arb_mvp: RTL and testbench
===================================

DIV_SQRT_ARB_MVP -- requirements
Module: div_sqrt_arb_mvp

Interface
REQ-001 SHALL have parameter: TAG_W, default 3, width of the requester tag returned with each result.
REQ-002 SHALL have port: Clk_CI  in  1  single clock, all state on the rising edge.
REQ-003 SHALL have port: Rst_RI  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: Req_valid_SI in 2, Req_ready_SO out 2  per-requester issue handshake (index i = requester i).
REQ-005 SHALL have ports (per requester i, packed): Req_op_SI in 2 (0 div, 1 sqrt), Req_fmt_SI in 4, Req_prec_SI in 12, Req_mant_a_DI in 106, Req_mant_b_DI in 106, Req_exp_a_DI in 24, Req_exp_b_DI in 24, Req_tag_DI in 2*TAG_W.
REQ-006 SHALL have port: Flush_SI  in  2  requester i abandons its outstanding operation.
REQ-007 SHALL have datapath ports: Dp_div_start_SO, Dp_sqrt_start_SO, Dp_start_SO, Dp_kill_SO out 1; Dp_fmt_SO out 2; Dp_prec_SO out 6; Dp_mant_a_DO, Dp_mant_b_DO out 53; Dp_exp_a_DO, Dp_exp_b_DO out 12.
REQ-008 SHALL have datapath inputs: Dp_ready_SI in 1, Dp_done_SI in 1, Dp_mant_z_DI in 57, Dp_exp_z_DI in 13.
REQ-009 SHALL have response ports: Rsp_valid_SO out 2, Rsp_ready_SI in 2, Rsp_mant_z_DO out 57, Rsp_exp_z_DO out 13, Rsp_tag_DO out TAG_W (shared data bus, per-requester valid).
REQ-010 SHALL have port: Busy_SO  out  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, BUSY, HOLD; one operation in flight at most.
REQ-012 IDLE: Req_ready_SO[i] SHALL be 1 only for the arbitration winner, only when Dp_ready_SI=1 and Flush_SI[i]=0; all other ready bits 0.
REQ-013 Arbitration SHALL be round-robin over valid requests: priority pointer favours requester ptr; after a grant to i, ptr becomes 1-i; sole valid requester always wins.
REQ-014 On Req_valid_SI[i]&Req_ready_SO[i] SHALL register requester i's op, fmt, prec, operands, tag and owner=i, then go ISSUE.
REQ-015 ISSUE (exactly one cycle): Dp_start_SO=1 and Dp_div_start_SO or Dp_sqrt_start_SO=1 per registered op; then BUSY.
REQ-016 Dp_fmt/prec/mant/exp outputs SHALL be driven from the registered copy, stable from ISSUE until the next accept.
REQ-017 BUSY: SHALL wait for Dp_done_SI=1 (sampled only in BUSY), capture Dp_mant_z_DI/Dp_exp_z_DI with registered tag, go HOLD.
REQ-018 HOLD: Rsp_valid_SO[owner]=1, other bit 0; response data stable; on Rsp_ready_SI[owner]=1 go IDLE; Rsp_ready of non-owner ignored.
REQ-019 Minimum latency: accept cycle T, start pulse T+1, Rsp_valid at cycle after Dp_done_SI; next accept earliest the cycle after response handshake.
REQ-020 Flush_SI[owner] in ISSUE: no start pulse; Dp_kill_SO=1 that cycle; go IDLE; no response.
REQ-021 Flush_SI[owner] in BUSY: Dp_kill_SO=1 for one cycle; go IDLE; no response; flush wins over simultaneous Dp_done_SI.
REQ-022 Flush_SI[owner] in HOLD: result discarded, Rsp_valid_SO cleared next cycle, go IDLE, no kill pulse; flush wins over simultaneous Rsp_ready_SI.
REQ-023 Flush_SI of non-owner SHALL have no effect outside IDLE.
REQ-024 Dp_start_SO, Dp_*_start_SO, Dp_kill_SO SHALL never be asserted simultaneously, and never for more than one consecutive cycle.

Reset
REQ-025 Rst_RI=1 at a clock edge SHALL force IDLE, ptr=0, all outputs 0 (ready, valid, start, kill, data, Busy_SO) on the following cycle.
REQ-026 Reset mid-operation SHALL abandon the operation without kill pulse or response; datapath shares the same reset.

Verification
REQ-027 Single div: req0 valid, op=0, mant_a=1.5, mant_b=1.25 (FP64), tag=5 -> ready0 same cycle, Dp_div_start one cycle later, Rsp_valid_SO=01 with tag 5 after Dp_done_SI.
REQ-028 Contention: both valid continuously, 4 ops -> grant order 0,1,0,1; tags returned to correct requester.
REQ-029 Flush in BUSY: req1 sqrt, Flush_SI=10 three cycles after start -> one-cycle Dp_kill_SO, no Rsp_valid, Busy_SO=0 next cycle.
REQ-030 Done+flush same cycle -> no response, kill pulse; HOLD with Rsp_ready low 10 cycles -> data stable, no new accept.
REQ-031 Dp_ready_SI=0 in IDLE with requests pending -> Req_ready_SO=00; reset asserted in BUSY -> all outputs 0 next cycle, ptr=0.

Source files
------------

// File: rtl/div_sqrt_arb_mvp.sv
`default_nettype none
// ============================================================================
// Module   : div_sqrt_arb_mvp
// Purpose  : Two-requester round-robin front end for a shared div/sqrt
//            datapath. Accepts one operation at a time, pulses the datapath
//            start, waits for completion, and returns the result (with the
//            requester tag) on a shared response bus with per-requester valid.
//            Requesters may flush their outstanding operation at any stage.
// Ports    : Clk_CI / Rst_RI              - clock, synchronous active-high reset
//            Req_*  (2 requesters, packed) - issue handshake, op, format,
//                                            precision, operands, tag
//            Flush_SI                      - per-requester abandon
//            Dp_*_SO / Dp_*_SI/DI          - datapath start/kill, operands,
//                                            ready/done and result
//            Rsp_*                         - response handshake and data
//            Busy_SO                       - an operation is in progress
// Revision : 1.0 - initial release
// ============================================================================
module div_sqrt_arb_mvp #(
    parameter int TAG_W = 3
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,
    input  logic [1:0]           Req_valid_SI,
    output logic [1:0]           Req_ready_SO,
    input  logic [1:0]           Req_op_SI,
    input  logic [3:0]           Req_fmt_SI,
    input  logic [11:0]          Req_prec_SI,
    input  logic [105:0]         Req_mant_a_DI,
    input  logic [105:0]         Req_mant_b_DI,
    input  logic [23:0]          Req_exp_a_DI,
    input  logic [23:0]          Req_exp_b_DI,
    input  logic [2*TAG_W-1:0]   Req_tag_DI,
    input  logic [1:0]           Flush_SI,
    output logic                 Dp_div_start_SO,
    output logic                 Dp_sqrt_start_SO,
    output logic                 Dp_start_SO,
    output logic                 Dp_kill_SO,
    output logic [1:0]           Dp_fmt_SO,
    output logic [5:0]           Dp_prec_SO,
    output logic [52:0]          Dp_mant_a_DO,
    output logic [52:0]          Dp_mant_b_DO,
    output logic [11:0]          Dp_exp_a_DO,
    output logic [11:0]          Dp_exp_b_DO,
    input  logic                 Dp_ready_SI,
    input  logic                 Dp_done_SI,
    input  logic [56:0]          Dp_mant_z_DI,
    input  logic [12:0]          Dp_exp_z_DI,
    output logic [1:0]           Rsp_valid_SO,
    input  logic [1:0]           Rsp_ready_SI,
    output logic [56:0]          Rsp_mant_z_DO,
    output logic [12:0]          Rsp_exp_z_DO,
    output logic [TAG_W-1:0]     Rsp_tag_DO,
    output logic                 Busy_SO
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;
    localparam logic [1:0] c_ST_HOLD  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_ptr;
    logic              r_owner;
    logic              r_op;
    logic [1:0]        r_fmt;
    logic [5:0]        r_prec;
    logic [52:0]       r_mant_a;
    logic [52:0]       r_mant_b;
    logic [11:0]       r_exp_a;
    logic [11:0]       r_exp_b;
    logic [TAG_W-1:0]  r_tag;
    logic [56:0]       r_rsp_mant;
    logic [12:0]       r_rsp_exp;

    logic [1:0]        w_elig;
    logic              w_win;
    logic              w_accept;
    logic              w_own_flush;
    logic              w_start;
    logic              w_kill;
    logic              w_capture;
    logic [1:0]        w_rsp_valid;

    // A requester that is flushing in the same cycle is not eligible, so the
    // other requester can win instead of the grant being wasted.
    assign w_elig      = Req_valid_SI & ~Flush_SI;
    assign w_win       = w_elig[r_ptr] ? r_ptr : ~r_ptr;
    assign w_own_flush = Flush_SI[r_owner];

    always_comb begin
        Req_ready_SO = 2'b00;
        if ((r_state == c_ST_IDLE) && Dp_ready_SI && (|w_elig) && !Rst_RI) begin
            Req_ready_SO = w_win ? 2'b10 : 2'b01;
        end
    end

    assign w_accept = |Req_ready_SO;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_kill      = 1'b0;
        w_capture   = 1'b0;
        w_rsp_valid = 2'b00;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                // Flush before the start pulse: tell the datapath to drop it.
                if (w_own_flush) begin
                    w_kill      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_start     = 1'b1;
                    w_state_nxt = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                // Flush has priority over a completion in the same cycle.
                if (w_own_flush) begin
                    w_kill      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (Dp_done_SI) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                w_rsp_valid = r_owner ? 2'b10 : 2'b01;
                // Datapath already finished, so a flush here needs no kill.
                if (w_own_flush || Rsp_ready_SI[r_owner]) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_state    <= c_ST_IDLE;
            r_ptr      <= 1'b0;
            r_owner    <= 1'b0;
            r_op       <= 1'b0;
            r_fmt      <= '0;
            r_prec     <= '0;
            r_mant_a   <= '0;
            r_mant_b   <= '0;
            r_exp_a    <= '0;
            r_exp_b    <= '0;
            r_tag      <= '0;
            r_rsp_mant <= '0;
            r_rsp_exp  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ptr    <= ~w_win;
                r_owner  <= w_win;
                r_op     <= w_win ? Req_op_SI[1] : Req_op_SI[0];
                r_fmt    <= w_win ? Req_fmt_SI[3:2] : Req_fmt_SI[1:0];
                r_prec   <= w_win ? Req_prec_SI[11:6] : Req_prec_SI[5:0];
                r_mant_a <= w_win ? Req_mant_a_DI[105:53] : Req_mant_a_DI[52:0];
                r_mant_b <= w_win ? Req_mant_b_DI[105:53] : Req_mant_b_DI[52:0];
                r_exp_a  <= w_win ? Req_exp_a_DI[23:12] : Req_exp_a_DI[11:0];
                r_exp_b  <= w_win ? Req_exp_b_DI[23:12] : Req_exp_b_DI[11:0];
                r_tag    <= w_win ? Req_tag_DI[2*TAG_W-1:TAG_W] : Req_tag_DI[TAG_W-1:0];
            end
            if (w_capture) begin
                r_rsp_mant <= Dp_mant_z_DI;
                r_rsp_exp  <= Dp_exp_z_DI;
            end
        end
    end

    assign Dp_start_SO      = w_start;
    assign Dp_div_start_SO  = w_start & ~r_op;
    assign Dp_sqrt_start_SO = w_start & r_op;
    assign Dp_kill_SO       = w_kill;
    assign Dp_fmt_SO        = r_fmt;
    assign Dp_prec_SO       = r_prec;
    assign Dp_mant_a_DO     = r_mant_a;
    assign Dp_mant_b_DO     = r_mant_b;
    assign Dp_exp_a_DO      = r_exp_a;
    assign Dp_exp_b_DO      = r_exp_b;
    assign Rsp_valid_SO     = w_rsp_valid;
    assign Rsp_mant_z_DO    = r_rsp_mant;
    assign Rsp_exp_z_DO     = r_rsp_exp;
    assign Rsp_tag_DO       = r_tag;
    assign Busy_SO          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_sqrt_arb_mvp.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_sqrt_arb_mvp
// Purpose  : Self-checking bench for div_sqrt_arb_mvp. Table-driven
//            transactions, randomized transactions against a round-robin
//            reference model, and directed flush / reset / back-pressure
//            sequences. A stub datapath is played by the bench itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_sqrt_arb_mvp;

    localparam int TAG_W = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          Req_valid_SI;
    logic [1:0]          Req_ready_SO;
    logic [1:0]          Req_op_SI;
    logic [3:0]          Req_fmt_SI;
    logic [11:0]         Req_prec_SI;
    logic [105:0]        Req_mant_a_DI;
    logic [105:0]        Req_mant_b_DI;
    logic [23:0]         Req_exp_a_DI;
    logic [23:0]         Req_exp_b_DI;
    logic [2*TAG_W-1:0]  Req_tag_DI;
    logic [1:0]          Flush_SI;
    logic                Dp_div_start_SO, Dp_sqrt_start_SO, Dp_start_SO, Dp_kill_SO;
    logic [1:0]          Dp_fmt_SO;
    logic [5:0]          Dp_prec_SO;
    logic [52:0]         Dp_mant_a_DO, Dp_mant_b_DO;
    logic [11:0]         Dp_exp_a_DO, Dp_exp_b_DO;
    logic                Dp_ready_SI, Dp_done_SI;
    logic [56:0]         Dp_mant_z_DI;
    logic [12:0]         Dp_exp_z_DI;
    logic [1:0]          Rsp_valid_SO;
    logic [1:0]          Rsp_ready_SI;
    logic [56:0]         Rsp_mant_z_DO;
    logic [12:0]         Rsp_exp_z_DO;
    logic [TAG_W-1:0]    Rsp_tag_DO;
    logic                Busy_SO;

    always #5 clk = ~clk;

    div_sqrt_arb_mvp #(.TAG_W(TAG_W)) dut (
        .Clk_CI(clk), .Rst_RI(rst),
        .Req_valid_SI(Req_valid_SI), .Req_ready_SO(Req_ready_SO),
        .Req_op_SI(Req_op_SI), .Req_fmt_SI(Req_fmt_SI), .Req_prec_SI(Req_prec_SI),
        .Req_mant_a_DI(Req_mant_a_DI), .Req_mant_b_DI(Req_mant_b_DI),
        .Req_exp_a_DI(Req_exp_a_DI), .Req_exp_b_DI(Req_exp_b_DI),
        .Req_tag_DI(Req_tag_DI), .Flush_SI(Flush_SI),
        .Dp_div_start_SO(Dp_div_start_SO), .Dp_sqrt_start_SO(Dp_sqrt_start_SO),
        .Dp_start_SO(Dp_start_SO), .Dp_kill_SO(Dp_kill_SO),
        .Dp_fmt_SO(Dp_fmt_SO), .Dp_prec_SO(Dp_prec_SO),
        .Dp_mant_a_DO(Dp_mant_a_DO), .Dp_mant_b_DO(Dp_mant_b_DO),
        .Dp_exp_a_DO(Dp_exp_a_DO), .Dp_exp_b_DO(Dp_exp_b_DO),
        .Dp_ready_SI(Dp_ready_SI), .Dp_done_SI(Dp_done_SI),
        .Dp_mant_z_DI(Dp_mant_z_DI), .Dp_exp_z_DI(Dp_exp_z_DI),
        .Rsp_valid_SO(Rsp_valid_SO), .Rsp_ready_SI(Rsp_ready_SI),
        .Rsp_mant_z_DO(Rsp_mant_z_DO), .Rsp_exp_z_DO(Rsp_exp_z_DO),
        .Rsp_tag_DO(Rsp_tag_DO), .Busy_SO(Busy_SO)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-requester operation fields, packed onto the request buses.
    logic             op_v   [2];
    logic [1:0]       fmt_v  [2];
    logic [5:0]       prec_v [2];
    logic [52:0]      ma_v   [2];
    logic [52:0]      mb_v   [2];
    logic [11:0]      ea_v   [2];
    logic [11:0]      eb_v   [2];
    logic [TAG_W-1:0] tag_v  [2];

    // Reference arbitration state: which requester is currently favoured.
    int model_ptr = 0;

    typedef struct {
        logic [1:0]       vmask;
        logic             op0;
        logic             op1;
        logic [TAG_W-1:0] tag0;
        logic [TAG_W-1:0] tag1;
        int               lat;
        int               hold;
        int               owner;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_winner(input logic [1:0] elig);
        if (elig == 2'b00) return -1;
        if (elig[model_ptr]) return model_ptr;
        return 1 - model_ptr;
    endfunction

    function automatic logic [1:0] onehot(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic drive_bus();
        Req_op_SI     = {op_v[1], op_v[0]};
        Req_fmt_SI    = {fmt_v[1], fmt_v[0]};
        Req_prec_SI   = {prec_v[1], prec_v[0]};
        Req_mant_a_DI = {ma_v[1], ma_v[0]};
        Req_mant_b_DI = {mb_v[1], mb_v[0]};
        Req_exp_a_DI  = {ea_v[1], ea_v[0]};
        Req_exp_b_DI  = {eb_v[1], eb_v[0]};
        Req_tag_DI    = {tag_v[1], tag_v[0]};
    endtask

    task automatic rand_operands(input int r);
        fmt_v[r]  = 2'($urandom());
        prec_v[r] = 6'($urandom());
        ma_v[r]   = 53'({$urandom(), $urandom()});
        mb_v[r]   = 53'({$urandom(), $urandom()});
        ea_v[r]   = 12'($urandom());
        eb_v[r]   = 12'($urandom());
    endtask

    // Full transaction: arbitration, start pulse, datapath completion after
    // lat BUSY cycles, response held for hold cycles, then handshake.
    task automatic do_txn(input logic [1:0] vmask, input int o, input int lat, input int hold);
        logic [56:0] zm;
        logic [12:0] ze;
        Flush_SI     = 2'b00;
        Rsp_ready_SI = 2'b00;
        drive_bus();
        Req_valid_SI = vmask;
        #1;
        check("grant_ready", Req_ready_SO, onehot(o));
        tick();
        model_ptr = 1 - o;
        check("start_pulse", Dp_start_SO, 1'b1);
        check("op_start", {Dp_div_start_SO, Dp_sqrt_start_SO}, op_v[o] ? 2'b01 : 2'b10);
        check("dp_mant_a", Dp_mant_a_DO, ma_v[o]);
        check("dp_mant_b", Dp_mant_b_DO, mb_v[o]);
        check("dp_exp", {Dp_exp_a_DO, Dp_exp_b_DO}, {ea_v[o], eb_v[o]});
        check("dp_fmt_prec", {Dp_fmt_SO, Dp_prec_SO}, {fmt_v[o], prec_v[o]});
        check("ready_in_issue", Req_ready_SO, 2'b00);
        tick();
        for (int i = 0; i < lat; i++) begin
            check("no_rsp_in_busy", Rsp_valid_SO, 2'b00);
            check("busy_flag", Busy_SO, 1'b1);
            tick();
        end
        zm = 57'({$urandom(), $urandom()});
        ze = 13'($urandom());
        Dp_done_SI   = 1'b1;
        Dp_mant_z_DI = zm;
        Dp_exp_z_DI  = ze;
        tick();
        Dp_done_SI = 1'b0;
        check("rsp_valid", Rsp_valid_SO, onehot(o));
        check("rsp_tag", Rsp_tag_DO, tag_v[o]);
        check("rsp_mant", Rsp_mant_z_DO, zm);
        check("rsp_exp", Rsp_exp_z_DO, ze);
        // Non-owner ready must be ignored; new requests must not be accepted.
        Rsp_ready_SI = onehot(1 - o);
        Dp_mant_z_DI = ~zm;
        Req_valid_SI = 2'b11;
        #1;
        check("no_accept_in_hold", Req_ready_SO, 2'b00);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", Rsp_valid_SO, onehot(o));
            check("hold_data", {Rsp_mant_z_DO, Rsp_exp_z_DO}, {zm, ze});
            check("hold_no_ready", Req_ready_SO, 2'b00);
        end
        Req_valid_SI = 2'b00;
        Rsp_ready_SI = onehot(o);
        tick();
        Rsp_ready_SI = 2'b00;
        check("rsp_done_valid", Rsp_valid_SO, 2'b00);
        check("rsp_done_busy", Busy_SO, 1'b0);
    endtask

    // Get a single requester accepted; leaves the DUT in ISSUE at return.
    task automatic accept_only(input int r, input logic opv);
        op_v[r] = opv;
        rand_operands(r);
        tag_v[r] = TAG_W'($urandom());
        drive_bus();
        Req_valid_SI = onehot(r);
        #1;
        check("acc_ready", Req_ready_SO, onehot(r));
        tick();
        Req_valid_SI = 2'b00;
        model_ptr = 1 - r;
    endtask

    // Datapath control pulses: exclusive and never two cycles in a row.
    initial begin
        logic p_start, p_div, p_sqrt, p_kill;
        p_start = 0; p_div = 0; p_sqrt = 0; p_kill = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                n_checks++;
                if ((Dp_kill_SO && Dp_start_SO) || (Dp_div_start_SO && Dp_sqrt_start_SO) ||
                    (Dp_start_SO !== (Dp_div_start_SO | Dp_sqrt_start_SO)) ||
                    (Dp_start_SO && p_start) || (Dp_div_start_SO && p_div) ||
                    (Dp_sqrt_start_SO && p_sqrt) || (Dp_kill_SO && p_kill)) begin
                    n_errors++;
                    $display("FAIL pulse_rules: start=%b div=%b sqrt=%b kill=%b required exclusive single-cycle",
                             Dp_start_SO, Dp_div_start_SO, Dp_sqrt_start_SO, Dp_kill_SO);
                end
            end
            p_start = Dp_start_SO; p_div = Dp_div_start_SO;
            p_sqrt = Dp_sqrt_start_SO; p_kill = Dp_kill_SO;
        end
    end

    initial begin
        int w;
        logic [1:0] vm;
        //                vmask  op0   op1   tag0  tag1  lat hold owner
        vecs[0] = '{2'b11, 1'b0, 1'b1, 3'd1, 3'd2, 1, 0,  0};
        vecs[1] = '{2'b11, 1'b0, 1'b1, 3'd3, 3'd4, 0, 1,  1};
        vecs[2] = '{2'b11, 1'b1, 1'b0, 3'd5, 3'd6, 2, 0,  0};
        vecs[3] = '{2'b11, 1'b1, 1'b1, 3'd7, 3'd0, 3, 10, 1};
        vecs[4] = '{2'b01, 1'b0, 1'b0, 3'd2, 3'd3, 0, 0,  0};
        vecs[5] = '{2'b10, 1'b1, 1'b1, 3'd4, 3'd1, 1, 2,  1};
        vecs[6] = '{2'b10, 1'b0, 1'b0, 3'd6, 3'd5, 0, 0,  1};
        vecs[7] = '{2'b11, 1'b1, 1'b0, 3'd0, 3'd7, 4, 1,  0};

        for (int r = 0; r < 2; r++) begin
            op_v[r] = 0; fmt_v[r] = 0; prec_v[r] = 0; ma_v[r] = 0;
            mb_v[r] = 0; ea_v[r] = 0; eb_v[r] = 0; tag_v[r] = 0;
        end
        drive_bus();
        rst = 1'b1; Req_valid_SI = 0; Flush_SI = 0; Dp_ready_SI = 1'b1;
        Dp_done_SI = 0; Dp_mant_z_DI = 0; Dp_exp_z_DI = 0; Rsp_ready_SI = 0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset_outputs",
              {Req_ready_SO, Rsp_valid_SO, Dp_start_SO, Dp_kill_SO, Busy_SO}, '0);
        check("reset_data", {Rsp_mant_z_DO, Rsp_tag_DO}, '0);

        // Table: contention 0,1,0,1 then sole-requester and mixed cases.
        for (int i = 0; i < 8; i++) begin
            op_v[0] = vecs[i].op0; op_v[1] = vecs[i].op1;
            tag_v[0] = vecs[i].tag0; tag_v[1] = vecs[i].tag1;
            rand_operands(0); rand_operands(1);
            do_txn(vecs[i].vmask, vecs[i].owner, vecs[i].lat, vecs[i].hold);
        end

        // Single FP64 divide 1.5 / 1.25, tag 5.
        op_v[0] = 1'b0; fmt_v[0] = 2'd0; prec_v[0] = 6'd53;
        ma_v[0] = 53'h18_0000_0000_0000; mb_v[0] = 53'h14_0000_0000_0000;
        ea_v[0] = 12'h3FF; eb_v[0] = 12'h3FF; tag_v[0] = 3'd5;
        do_txn(2'b01, 0, 2, 1);

        // Randomized transactions against the round-robin model.
        for (int i = 0; i < 20; i++) begin
            vm = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                op_v[r] = 1'($urandom()); tag_v[r] = TAG_W'($urandom());
                rand_operands(r);
            end
            w = model_winner(vm);
            do_txn(vm, w, $urandom_range(0, 4), $urandom_range(0, 3));
        end

        // Flush in ISSUE: kill instead of start, back to idle, no response.
        accept_only(0, 1'b0);
        Flush_SI = 2'b01;
        #1;
        check("issue_flush_kill", {Dp_kill_SO, Dp_start_SO}, 2'b10);
        tick();
        Flush_SI = 2'b00;
        check("issue_flush_idle", {Busy_SO, Rsp_valid_SO, Dp_kill_SO}, '0);

        // Flush in BUSY three cycles after start; non-owner flush ignored first.
        accept_only(1, 1'b1);
        check("sqrt_start", {Dp_start_SO, Dp_sqrt_start_SO, Dp_div_start_SO}, 3'b110);
        tick();
        Flush_SI = 2'b01;
        #1;
        check("nonowner_flush_nokill", Dp_kill_SO, 1'b0);
        tick();
        Flush_SI = 2'b00;
        check("nonowner_flush_busy", Busy_SO, 1'b1);
        tick();
        Flush_SI = 2'b10;
        #1;
        check("busy_flush_kill", Dp_kill_SO, 1'b1);
        tick();
        Flush_SI = 2'b00;
        check("busy_flush_after", {Busy_SO, Rsp_valid_SO, Dp_kill_SO}, '0);
        repeat (2) begin
            tick();
            check("busy_flush_no_rsp", Rsp_valid_SO, 2'b00);
        end

        // Done and flush together: flush wins.
        accept_only(0, 1'b0);
        tick();
        Dp_done_SI = 1'b1; Flush_SI = 2'b01;
        #1;
        check("doneflush_kill", Dp_kill_SO, 1'b1);
        tick();
        Dp_done_SI = 1'b0; Flush_SI = 2'b00;
        check("doneflush_after", {Busy_SO, Rsp_valid_SO}, '0);

        // Flush in HOLD with simultaneous owner ready: no kill, no handshake.
        accept_only(1, 1'b0);
        tick();
        Dp_done_SI = 1'b1;
        tick();
        Dp_done_SI = 1'b0;
        check("hold_entry", Rsp_valid_SO, 2'b10);
        Flush_SI = 2'b10; Rsp_ready_SI = 2'b10;
        #1;
        check("hold_flush_nokill", Dp_kill_SO, 1'b0);
        tick();
        Flush_SI = 2'b00; Rsp_ready_SI = 2'b00;
        check("hold_flush_after", {Busy_SO, Rsp_valid_SO}, '0);

        // Back-pressure and flushing requesters in IDLE.
        Dp_ready_SI = 1'b0; Req_valid_SI = 2'b11;
        #1;
        check("dp_not_ready", Req_ready_SO, 2'b00);
        tick();
        check("dp_not_ready_idle", Busy_SO, 1'b0);
        Dp_ready_SI = 1'b1; Flush_SI = 2'b11;
        #1;
        check("both_flushing", Req_ready_SO, 2'b00);
        Flush_SI = 2'b10;
        #1;
        check("flushing_loses", Req_ready_SO, 2'b01);
        Req_valid_SI = 2'b00; Flush_SI = 2'b00;

        // Reset in BUSY after a grant to 0 (which favours 1): pointer returns to 0.
        accept_only(0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_ptr = 0;
        check("rst_busy_ctrl",
              {Req_ready_SO, Rsp_valid_SO, Dp_start_SO, Dp_kill_SO, Busy_SO}, '0);
        check("rst_busy_data", {Dp_mant_a_DO, Dp_exp_a_DO, Rsp_tag_DO}, '0);
        for (int r = 0; r < 2; r++) begin
            rand_operands(r); op_v[r] = 1'($urandom()); tag_v[r] = TAG_W'($urandom());
        end
        do_txn(2'b11, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
